// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encodings and the CPU-wide default width.
package seq_divider_pkg;

  localparam int BW_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface seq_divider_if #(
  parameter int BW = 16
);
  logic          start;
  logic [BW-1:0] dividend;
  logic [BW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [BW-1:0] quotient;
  logic [BW-1:0] remainder;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divider_rca.sv
// Ripple-carry adder shared with the ALU path; carry-out and signed overflow flags.
module seq_divider_rca #(
  parameter int W = 17
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         cout_F,
  output logic         ov
);

  logic carry;
  logic carry_msb;

  always_comb begin
    carry     = ci;
    carry_msb = ci;
    s         = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) carry_msb = carry;
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout_F = carry;
    ov     = carry ^ carry_msb;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results held until the next op.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(BW);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [BW-1:0] d;
  logic [BW-1:0] q;
  logic [BW-1:0] r;
  logic [BW:0]   rs;
  logic [BW:0]   d_inv;
  logic [BW:0]   trial;
  logic          no_borrow;
  logic          ov_unused;
  logic          trial_msb_unused;
  logic [BW-1:0] r_next;
  logic [BW-1:0] q_next;
  logic          accept;
  logic          last_iter;

  // Trial subtract rs - d as rs + ~d + 1; carry-out set means no borrow.
  assign rs    = {r, q[BW-1]};
  assign d_inv = ~{1'b0, d};

  seq_divider_rca #(.W(BW + 1)) u_rca (
    .x      (rs),
    .y      (d_inv),
    .ci     (1'b1),
    .s      (trial),
    .cout_F (no_borrow),
    .ov     (ov_unused)
  );

  // A kept difference is below d, so its top bit is always zero; likewise a restored rs.
  assign trial_msb_unused = trial[BW];
  assign r_next    = no_borrow ? trial[BW-1:0] : rs[BW-1:0];
  assign q_next    = {q[BW-2:0], no_borrow};
  assign accept    = bus.start && (state != ST_RUN);
  assign last_iter = (count == CW'(BW - 1));

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      count         <= '0;
      d             <= '0;
      q             <= '0;
      r             <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
    end else if (accept) begin
      d     <= bus.divisor;
      q     <= bus.dividend;
      r     <= '0;
      count <= '0;
      if (bus.divisor == '0) begin
        state         <= ST_DONE;
        bus.quotient  <= '1;
        bus.remainder <= bus.dividend;
        bus.div_zero  <= 1'b1;
      end else begin
        state <= ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + CW'(1);
          if (last_iter) begin
            state         <= ST_DONE;
            bus.quotient  <= q_next;
            bus.remainder <= r_next;
            bus.div_zero  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
